// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage.
// Holds the PC, requests words from instruction memory over req/ack, and
// captures them into the IF/ID register. It has a one-entry hold buffer for a
// word that arrives while decode is stalled. DRAIN waits out a request that
// was in flight when a branch redirected fetch.
// Optional macro FETCH_PREDECODE_EN drives imm_d/imm_src_d from instr_d;
// without it both outputs are tied to zero.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus8_d,
   output logic        valid_d,
   output logic [23:0] imm_d,
   output logic [1:0]  imm_src_d
);

   typedef enum logic [1:0] {StFetch, StDrain, StHold} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] drain_addr_q;   // address of the request being drained
   logic [31:0] hold_instr_q;
   logic [31:0] hold_pc_q;
   logic [31:0] pc_inc;
   logic [31:0] target_aligned;

   assign pc_inc         = pc_q + 32'd4;
   assign target_aligned = branch_target & 32'hFFFF_FFFC;

   // DRAIN keeps presenting the old address while pc_q already holds the target.
   assign imem_req   = !rst && (state_q != StHold);
   assign imem_addr  = rst ? RESET_PC : ((state_q == StDrain) ? drain_addr_q : pc_q);
   assign pc_plus8_d = pc_d + 32'd8;

   // State, PC, hold buffer and IF/ID register; priority rst > branch > flush > stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StFetch;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
         instr_d      <= '0;
         pc_d         <= '0;
         valid_d      <= 1'b0;
      end else if (branch_taken) begin
         pc_q <= target_aligned;
         if (flush || !stall) begin
            valid_d <= 1'b0;
         end
         if ((state_q == StFetch) && !imem_ack) begin
            state_q      <= StDrain;
            drain_addr_q <= pc_q;
         end else if ((state_q == StDrain) && !imem_ack) begin
            state_q <= StDrain;
         end else begin
            // Any ack in this cycle is discarded; the hold buffer is dropped.
            state_q <= StFetch;
         end
      end else if (flush) begin
         // The word captured this cycle is lost; the PC still advances.
         valid_d <= 1'b0;
         unique case (state_q)
            StFetch: begin
               if (imem_ack) begin
                  pc_q <= pc_inc;
               end
            end
            StDrain: begin
               if (imem_ack) begin
                  state_q <= StFetch;
               end
            end
            StHold:  state_q <= StFetch;
            default: state_q <= StFetch;
         endcase
      end else begin
         unique case (state_q)
            StFetch: begin
               if (imem_ack) begin
                  pc_q <= pc_inc;
                  if (stall) begin
                     hold_instr_q <= imem_rdata;
                     hold_pc_q    <= pc_q;
                     state_q      <= StHold;
                  end else begin
                     instr_d <= imem_rdata;
                     pc_d    <= pc_q;
                     valid_d <= 1'b1;
                  end
               end else if (!stall) begin
                  valid_d <= 1'b0;
               end
            end
            StDrain: begin
               if (imem_ack) begin
                  state_q <= StFetch;
               end
               if (!stall) begin
                  valid_d <= 1'b0;
               end
            end
            StHold: begin
               if (!stall) begin
                  instr_d <= hold_instr_q;
                  pc_d    <= hold_pc_q;
                  valid_d <= 1'b1;
                  state_q <= StFetch;
               end
            end
            default: state_q <= StFetch;
         endcase
      end
   end

`ifdef FETCH_PREDECODE_EN
   // The selector encoding matches instr_d[27:26] directly.
   assign imm_d     = instr_d[23:0];
   assign imm_src_d = instr_d[27:26];
`else
   assign imm_d     = '0;
   assign imm_src_d = '0;
`endif

endmodule
